operand_entry: RTL and testbench
================================

Name: operand_entry

Overview:
- Upstream input stage of the calculator datapath; owns the board switches and buttons.
- Debounces the push-buttons and sequences operand capture (op1, then op2) through a 3-state FSM.
- Drives stable registered op1/op2/operation/sign to the mini ALU, plus a result_valid flag and phase code for status LEDs.
- The display path shows the ALU result only while result_valid is high.

Parameters:
DEBOUNCE_CYCLES, 1_000_000, cycles a raw button level must hold before it is accepted (10 ms at 100 MHz); legal range 2 or more.
OP_W, 4, operand width; matches ALU operand ports.

Ports:
clk  input  1  system clock; all state on rising edge.
rst  input  1  synchronous, active-high reset.
sw  input  OP_W  raw operand switches; sampled only on an enter press.
btn_enter  input  1  raw button: capture current operand / advance.
btn_op  input  1  raw button: toggle operation.
btn_sign  input  1  raw button: toggle sign mode.
btn_clear  input  1  raw button: abandon entry, return to op1 entry.
op1  output  OP_W  registered first operand.
op2  output  OP_W  registered second operand.
operation  output  1  registered ALU operation select.
sign  output  1  registered ALU signed/unsigned select.
result_valid  output  1  high only in state S_RESULT.
phase  output  2  state code: 0 = S_OP1, 1 = S_OP2, 2 = S_RESULT.

Behaviour:
- Clock and reset: one clock (clk). Reset rst is synchronous, active-high.
- Reset values: op1 = 0, op2 = 0, operation = 0, sign = 0, result_valid = 0, phase = 0 (S_OP1). All debouncer counters and stable levels are 0.
- Debounce, per button, run independently:
  - Counter clears whenever raw == stable.
  - Counter increments whenever raw != stable.
  - When the counter reaches DEBOUNCE_CYCLES-1 with raw still != stable: stable <= raw and the counter clears.
  - Net effect: a change becomes stable after DEBOUNCE_CYCLES consecutive differing cycles. Any shorter glitch is discarded.
- Press pulse: one-cycle pulse on the stable 0->1 transition. Release produces no pulse. Holding a button produces exactly one pulse.
- FSM acts in the cycle a pulse is high; outputs update on the next clock edge.
  - S_OP1 + enter: op1 <= sw; go to S_OP2.
  - S_OP2 + enter: op2 <= sw; go to S_RESULT; result_valid = 1.
  - S_RESULT + enter: op1 <= 0, op2 <= 0; go to S_OP1.
  - Any state + clear: op1 <= 0, op2 <= 0; go to S_OP1. operation and sign are kept.
  - Any state + op pulse: operation <= ~operation.
  - Any state + sign pulse: sign <= ~sign.
- Simultaneous events:
  - clear and enter in the same cycle: clear wins; enter is ignored.
  - A toggle pulse together with enter or clear: both actions apply.
  - op and sign pulses in the same cycle: both toggle.
- sw changes outside an enter pulse have no effect.
- Reset mid-debounce or mid-entry returns everything to reset values. A button held through reset release produces a pulse DEBOUNCE_CYCLES cycles later, because the stable level restarts at 0.
- Unreachable state encoding (3) returns to S_OP1 with op1 = op2 = 0.
- Latency, raw press to output change: DEBOUNCE_CYCLES + 1 clocks, or +3 with the optional synchroniser.

Optional Feature:
OPERAND_ENTRY_SYNC_EN:
- Defined: each raw button and each sw bit passes through a 2-flop synchroniser (reset 0) before the debouncer/capture. Adds 2 cycles of latency.
- Undefined: raw inputs feed the debouncer and capture directly. Intended for simulation and synchronous benches.

Decomposition:
- Package calc_pkg:
  - entry_state_t enum {S_OP1 = 2'd0, S_OP2 = 2'd1, S_RESULT = 2'd2}.
  - Localparam OP_W_DEFAULT = 4.
- Sub-module btn_debounce, instantiated 4x:
  - Parameter DEBOUNCE_CYCLES.
  - Ports clk, rst, raw, stable, press.
  - Synchroniser, when enabled, lives inside it.
- The FSM and operand registers stay in operand_entry.

Test Plan (DEBOUNCE_CYCLES = 4, no sync macro):
- Reset, then idle 10 cycles -> all outputs 0, phase = 0.
- sw = 4'h5, btn_enter high 6 cycles -> op1 = 5, phase = 1, exactly 5 clocks after enter rises. Then sw = 4'h3, enter again -> op2 = 3, phase = 2, result_valid = 1.
- btn_enter glitches high for 3 cycles, then low -> no state change, op1 unchanged.
- In S_OP2, assert btn_clear and btn_enter together (held 6 cycles) -> phase = 0, op1 = op2 = 0, no capture.
- Press btn_op twice and btn_sign once, each held 6 cycles with gaps -> operation = 0, sign = 1. Hold btn_op 50 cycles -> single toggle.
- Assert rst while btn_enter has been held 2 cycles into debounce, release rst with enter still held -> all reset values; capture occurs 5 cycles after rst drops.

Source files
------------

// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : calc_pkg
//  Description : Shared types and defaults for the calculator entry datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
package calc_pkg;

   typedef enum logic [1:0] {
      S_OP1    = 2'd0,
      S_OP2    = 2'd1,
      S_RESULT = 2'd2
   } entry_state_t;

   localparam int OP_W_DEFAULT = 4;

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : btn_debounce
//  Description : Counter debouncer with one-cycle press pulse on stable 0->1.
//                Optional 2-flop input synchroniser under OPERAND_ENTRY_SYNC_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic stable,
   output logic press
);

   localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic raw_s;

`ifdef OPERAND_ENTRY_SYNC_EN
   logic [1:0] sync_q;

   always_ff @(posedge clk) begin
      if (rst) sync_q <= 2'b00;
      else     sync_q <= {sync_q[0], raw};
   end

   assign raw_s = sync_q[1];
`else
   assign raw_s = raw;
`endif

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             stable_q, stable_d;
   logic             press_q, press_d;

   // Counter length equals the number of consecutive differing samples seen.
   always_comb begin
      cnt_d    = cnt_q;
      stable_d = stable_q;
      press_d  = 1'b0;
      if (raw_s == stable_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         cnt_d    = '0;
         stable_d = raw_s;
         press_d  = raw_s;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q    <= '0;
         stable_q <= 1'b0;
         press_q  <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         stable_q <= stable_d;
         press_q  <= press_d;
      end
   end

   assign stable = stable_q;
   assign press  = press_q;

endmodule
`default_nettype wire

// File: rtl/operand_entry.sv
`default_nettype none
// ============================================================================
//  Module      : operand_entry
//  Description : Debounced button front end and op1/op2 capture FSM feeding the
//                mini ALU. Define OPERAND_ENTRY_SYNC_EN to synchronise inputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module operand_entry
   import calc_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int OP_W            = OP_W_DEFAULT
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [OP_W-1:0] sw,
   input  logic            btn_enter,
   input  logic            btn_op,
   input  logic            btn_sign,
   input  logic            btn_clear,
   output logic [OP_W-1:0] op1,
   output logic [OP_W-1:0] op2,
   output logic            operation,
   output logic            sign,
   output logic            result_valid,
   output logic [1:0]      phase
);

   localparam logic [1:0] ST_OP1    = S_OP1;
   localparam logic [1:0] ST_OP2    = S_OP2;
   localparam logic [1:0] ST_RESULT = S_RESULT;

   localparam int BTN_ENTER = 0;
   localparam int BTN_OP    = 1;
   localparam int BTN_SIGN  = 2;
   localparam int BTN_CLEAR = 3;

   logic [3:0]      w_raw;
   logic [3:0]      w_press;
   logic [OP_W-1:0] w_sw;

   assign w_raw = {btn_clear, btn_sign, btn_op, btn_enter};

`ifdef OPERAND_ENTRY_SYNC_EN
   // Matches the button synchroniser depth so sw is aligned with the pulse.
   logic [OP_W-1:0] sw_meta_q, sw_sync_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sw_meta_q <= '0;
         sw_sync_q <= '0;
      end else begin
         sw_meta_q <= sw;
         sw_sync_q <= sw_meta_q;
      end
   end

   assign w_sw = sw_sync_q;
`else
   assign w_sw = sw;
`endif

   for (genvar i = 0; i < 4; i++) begin : g_btn
      btn_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
         .clk    (clk),
         .rst    (rst),
         .raw    (w_raw[i]),
         .stable (),
         .press  (w_press[i])
      );
   end

   logic [1:0]      state_q, state_d;
   logic [OP_W-1:0] op1_q, op1_d;
   logic [OP_W-1:0] op2_q, op2_d;
   logic            operation_q, operation_d;
   logic            sign_q, sign_d;

   // Clear overrides enter; toggles apply independently of both.
   always_comb begin
      state_d     = state_q;
      op1_d       = op1_q;
      op2_d       = op2_q;
      operation_d = operation_q ^ w_press[BTN_OP];
      sign_d      = sign_q ^ w_press[BTN_SIGN];
      if (w_press[BTN_CLEAR]) begin
         op1_d   = '0;
         op2_d   = '0;
         state_d = ST_OP1;
      end else begin
         case (state_q)
            ST_OP1: if (w_press[BTN_ENTER]) begin
               op1_d   = w_sw;
               state_d = ST_OP2;
            end
            ST_OP2: if (w_press[BTN_ENTER]) begin
               op2_d   = w_sw;
               state_d = ST_RESULT;
            end
            ST_RESULT: if (w_press[BTN_ENTER]) begin
               op1_d   = '0;
               op2_d   = '0;
               state_d = ST_OP1;
            end
            default: begin
               op1_d   = '0;
               op2_d   = '0;
               state_d = ST_OP1;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_OP1;
         op1_q       <= '0;
         op2_q       <= '0;
         operation_q <= 1'b0;
         sign_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         op1_q       <= op1_d;
         op2_q       <= op2_d;
         operation_q <= operation_d;
         sign_q      <= sign_d;
      end
   end

   assign op1          = op1_q;
   assign op2          = op2_q;
   assign operation    = operation_q;
   assign sign         = sign_q;
   assign phase        = state_q;
   assign result_valid = (state_q == ST_RESULT);

endmodule
`default_nettype wire

// File: tb/tb_operand_entry.sv
`default_nettype none
// ============================================================================
//  Module      : tb_operand_entry
//  Description : Self-checking bench for operand_entry (DEBOUNCE_CYCLES = 4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_operand_entry;

   localparam int D = 4;
   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [W-1:0] sw = '0;
   logic         btn_enter = 1'b0;
   logic         btn_op    = 1'b0;
   logic         btn_sign  = 1'b0;
   logic         btn_clear = 1'b0;

   wire [W-1:0] op1, op2;
   wire         operation, sign, result_valid;
   wire [1:0]   phase;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   operand_entry #(
      .DEBOUNCE_CYCLES(D),
      .OP_W           (W)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .sw           (sw),
      .btn_enter    (btn_enter),
      .btn_op       (btn_op),
      .btn_sign     (btn_sign),
      .btn_clear    (btn_clear),
      .op1          (op1),
      .op2          (op2),
      .operation    (operation),
      .sign         (sign),
      .result_valid (result_valid),
      .phase        (phase)
   );

   // Reference: a level is accepted once the last D samples all differ from it;
   // the press is seen by the FSM on the following edge.
   logic [D-1:0] m_hist [4];
   logic [3:0]   m_stable = '0;
   logic [3:0]   m_press  = '0;
   logic [W-1:0] m_op1 = '0, m_op2 = '0;
   logic         m_oper = 1'b0, m_sign = 1'b0;
   int           m_phase = 0;

   always @(posedge clk) begin : model
      logic [3:0]   raw, nst, npr;
      logic [D-1:0] win;
      logic [W-1:0] n1, n2;
      int           nph;
      raw = {btn_clear, btn_sign, btn_op, btn_enter};
      if (rst) begin
         m_stable <= '0;
         m_press  <= '0;
         m_op1    <= '0;
         m_op2    <= '0;
         m_oper   <= 1'b0;
         m_sign   <= 1'b0;
         m_phase  <= 0;
         for (int b = 0; b < 4; b++) m_hist[b] <= '0;
      end else begin
         n1  = m_op1;
         n2  = m_op2;
         nph = m_phase;
         if (m_press[3]) begin
            n1 = '0; n2 = '0; nph = 0;
         end else if (m_press[0]) begin
            if (m_phase == 0)      begin n1 = sw; nph = 1; end
            else if (m_phase == 1) begin n2 = sw; nph = 2; end
            else                   begin n1 = '0; n2 = '0; nph = 0; end
         end
         m_op1   <= n1;
         m_op2   <= n2;
         m_phase <= nph;
         m_oper  <= m_oper ^ m_press[1];
         m_sign  <= m_sign ^ m_press[2];
         for (int b = 0; b < 4; b++) begin
            win    = {m_hist[b][D-2:0], raw[b]};
            nst[b] = m_stable[b];
            npr[b] = 1'b0;
            if (!m_stable[b] && win == {D{1'b1}}) begin
               nst[b] = 1'b1;
               npr[b] = 1'b1;
            end else if (m_stable[b] && win == {D{1'b0}}) begin
               nst[b] = 1'b0;
            end
            m_hist[b] <= win;
         end
         m_stable <= nst;
         m_press  <= npr;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      chk("op1",          32'(op1),          32'(m_op1));
      chk("op2",          32'(op2),          32'(m_op2));
      chk("operation",    32'(operation),    32'(m_oper));
      chk("sign",         32'(sign),         32'(m_sign));
      chk("phase",        32'(phase),        32'(m_phase));
      chk("result_valid", 32'(result_valid), 32'(m_phase == 2));
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic set_btn(input int idx, input logic v);
      case (idx)
         0:       btn_enter = v;
         1:       btn_op    = v;
         2:       btn_sign  = v;
         default: btn_clear = v;
      endcase
   endtask

   task automatic press_btn(input int idx, input int hold);
      set_btn(idx, 1'b1);
      idle(hold);
      set_btn(idx, 1'b0);
      idle(8);
   endtask

   initial begin
      idle(3);
      rst = 1'b0;
      idle(10);
      chk("rst_op1",   32'(op1),          32'd0);
      chk("rst_op2",   32'(op2),          32'd0);
      chk("rst_oper",  32'(operation),    32'd0);
      chk("rst_sign",  32'(sign),         32'd0);
      chk("rst_rv",    32'(result_valid), 32'd0);
      chk("rst_phase", 32'(phase),        32'd0);

      // First capture: output must move exactly D+1 clocks after the press.
      sw = 4'h5;
      btn_enter = 1'b1;
      idle(4);
      chk("lat_early_phase", 32'(phase), 32'd0);
      tick();
      chk("lat_phase", 32'(phase), 32'd1);
      chk("lat_op1",   32'(op1),   32'd5);
      tick();
      btn_enter = 1'b0;
      idle(8);

      sw = 4'h3;
      press_btn(0, 6);
      chk("cap2_op2",   32'(op2),          32'd3);
      chk("cap2_phase", 32'(phase),        32'd2);
      chk("cap2_rv",    32'(result_valid), 32'd1);

      sw = 4'h0;
      press_btn(0, 3);
      chk("glitch_phase", 32'(phase), 32'd2);
      chk("glitch_op1",   32'(op1),   32'd5);

      press_btn(0, 6);
      chk("res_enter_phase", 32'(phase), 32'd0);
      chk("res_enter_op1",   32'(op1),   32'd0);

      sw = 4'h9;
      press_btn(0, 6);
      chk("cap9_op1", 32'(op1), 32'd9);

      btn_clear = 1'b1;
      btn_enter = 1'b1;
      idle(6);
      btn_clear = 1'b0;
      btn_enter = 1'b0;
      idle(8);
      chk("clr_phase", 32'(phase), 32'd0);
      chk("clr_op1",   32'(op1),   32'd0);
      chk("clr_op2",   32'(op2),   32'd0);

      press_btn(1, 6);
      press_btn(1, 6);
      press_btn(2, 6);
      chk("tog_oper", 32'(operation), 32'd0);
      chk("tog_sign", 32'(sign),      32'd1);
      press_btn(1, 50);
      chk("hold_oper", 32'(operation), 32'd1);

      // Reset mid-debounce with enter held through release.
      sw = 4'h6;
      btn_enter = 1'b1;
      idle(2);
      rst = 1'b1;
      idle(2);
      chk("mid_rst_oper",  32'(operation), 32'd0);
      chk("mid_rst_sign",  32'(sign),      32'd0);
      chk("mid_rst_phase", 32'(phase),     32'd0);
      rst = 1'b0;
      idle(4);
      chk("post_rst_early", 32'(phase), 32'd0);
      tick();
      chk("post_rst_phase", 32'(phase), 32'd1);
      chk("post_rst_op1",   32'(op1),   32'd6);
      btn_enter = 1'b0;
      idle(8);

      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 5) == 0) btn_enter = ~btn_enter;
         if ($urandom_range(0, 6) == 0) btn_op    = ~btn_op;
         if ($urandom_range(0, 6) == 0) btn_sign  = ~btn_sign;
         if ($urandom_range(0, 9) == 0) btn_clear = ~btn_clear;
         sw  = W'($urandom);
         rst = ($urandom_range(0, 399) == 0);
         tick();
      end
      rst       = 1'b0;
      btn_enter = 1'b0;
      btn_op    = 1'b0;
      btn_sign  = 1'b0;
      btn_clear = 1'b0;
      idle(10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
